// File: rtl/push_pop_sequencer.sv
// Thumb PUSH/POP sequencer: expands one request into per-register memory accesses
// followed by an SP writeback, owning the register-file and memory ports while busy.
//
// state    | meaning
// IDLE     | waiting for start, inputs captured on start
// SETUP    | register count, start address and final SP computed
// ACCESS   | one memory access per selected register, held until mem_ready
// WRITE_SP | final SP written to register 8
// DONE     | one-cycle completion pulse
module push_pop_sequencer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_pop,
  input  logic [7:0]        reg_list,
  input  logic              extra_bit,
  input  logic [ADDR_W-1:0] sp_in,
  input  logic [DATA_W-1:0] rf_read_data,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [3:0]        rf_read_sel,
  output logic [3:0]        rf_write_dest,
  output logic              rf_write_en,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_WRITE_SP,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic              is_pop_q, is_pop_d;
  logic [7:0]        list_q, list_d;
  logic              extra_q, extra_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] new_sp_q, new_sp_d;

  logic [3:0]        count;
  logic [ADDR_W-1:0] span;
  logic [3:0]        cur_reg;
  logic [7:0]        list_clr;
  logic              last;

  always_comb begin
    count = {3'b000, extra_q};
    for (int i = 0; i < 8; i++) begin
      count = count + {3'b000, list_q[i]};
    end
    span = ADDR_W'(count) << 2;
  end

  // Remaining low registers go first; the extra register (LR/PC) is always last.
  always_comb begin
    cur_reg = is_pop_q ? 4'd9 : 4'd10;
    for (int i = 7; i >= 0; i--) begin
      if (list_q[i]) cur_reg = 4'(i);
    end
    list_clr = list_q & (list_q - 8'd1);
    last     = (list_q != 8'd0) ? ((list_clr == 8'd0) && !extra_q) : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start) state_d = S_SETUP;
      S_SETUP:    state_d = (count == 4'd0) ? S_DONE : S_ACCESS;
      S_ACCESS:   if (mem_ready && last) state_d = S_WRITE_SP;
      S_WRITE_SP: state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    is_pop_d = is_pop_q;
    list_d   = list_q;
    extra_d  = extra_q;
    addr_d   = addr_q;
    new_sp_d = new_sp_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          is_pop_d = is_pop;
          list_d   = reg_list;
          extra_d  = extra_bit;
          addr_d   = sp_in;
        end
      end
      S_SETUP: begin
        addr_d   = is_pop_q ? addr_q : addr_q - span;
        new_sp_d = is_pop_q ? addr_q + span : addr_q - span;
      end
      S_ACCESS: begin
        if (mem_ready) begin
          if (list_q != 8'd0) list_d = list_clr;
          else                extra_d = 1'b0;
          addr_d = addr_q + ADDR_W'(4);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      is_pop_q <= 1'b0;
      list_q   <= '0;
      extra_q  <= 1'b0;
      addr_q   <= '0;
      new_sp_q <= '0;
    end else begin
      is_pop_q <= is_pop_d;
      list_q   <= list_d;
      extra_q  <= extra_d;
      addr_q   <= addr_d;
      new_sp_q <= new_sp_d;
    end
  end

  always_comb begin
    busy          = (state_q != S_IDLE);
    done          = (state_q == S_DONE);
    mem_req       = (state_q == S_ACCESS);
    mem_we        = mem_req && !is_pop_q;
    mem_addr      = mem_req ? addr_q : '0;
    rf_read_sel   = mem_we ? cur_reg : 4'd0;
    mem_wdata     = rf_read_data;
    rf_write_en   = 1'b0;
    rf_write_dest = 4'd0;
    rf_write_data = '0;
    if (mem_req && is_pop_q) begin
      rf_write_dest = cur_reg;
      if (mem_ready) begin
        rf_write_en   = 1'b1;
        rf_write_data = mem_rdata;
      end
    end
    if (state_q == S_WRITE_SP) begin
      rf_write_en   = 1'b1;
      rf_write_dest = 4'd8;
      rf_write_data = DATA_W'(new_sp_q);
    end
  end

endmodule

// File: tb/tb_push_pop_sequencer.sv
// Bench for push_pop_sequencer: register-file and memory environment, a transaction-level
// reference model checked every cycle, and directed PUSH/POP scenarios with literal results.
module tb_push_pop_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_pop;
  logic [7:0]  reg_list;
  logic        extra_bit;
  logic [31:0] sp_in;
  logic [31:0] rf_read_data;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;
  logic [3:0]  rf_read_sel;
  logic [3:0]  rf_write_dest;
  logic        rf_write_en;
  logic [31:0] rf_write_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  push_pop_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .is_pop(is_pop), .reg_list(reg_list),
    .extra_bit(extra_bit), .sp_in(sp_in), .rf_read_data(rf_read_data),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy), .done(done),
    .rf_read_sel(rf_read_sel), .rf_write_dest(rf_write_dest), .rf_write_en(rf_write_en),
    .rf_write_data(rf_write_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment: 16-entry register file and a 64-word memory indexed by addr[7:2].
  logic [31:0] rf  [16];
  logic [31:0] mem [64];
  assign rf_read_data = rf[rf_read_sel];
  assign mem_rdata    = mem[mem_addr[7:2]];

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0, req_cnt = 0, done_cnt = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%b required=%b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] memw(input logic [31:0] a);
    return mem[a[7:2]];
  endfunction

  // Reference model: the request as a list of registers in transfer order plus a position.
  // phase 0 idle, 1 setup, 2 transferring, 3 SP writeback, 4 done.
  logic        model_on = 1'b0;
  int          m_phase = 0;
  int          m_n = 0;
  int          m_k = 0;
  logic        m_pop = 1'b0;
  logic [3:0]  m_regs [9];
  logic [31:0] m_base = '0;
  logic [31:0] m_new_sp = '0;

  always @(posedge clk) begin
    if (rf_write_en === 1'b1) begin
      rf[rf_write_dest] = rf_write_data;
      wr_cnt++;
    end
    if (mem_req === 1'b1 && mem_we === 1'b1 && mem_ready) mem[mem_addr[7:2]] = mem_wdata;
    if (mem_req === 1'b1) req_cnt++;
    if (done === 1'b1) done_cnt++;

    if (rst) begin
      m_phase  = 0;
      model_on = 1'b1;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_pop = is_pop;
          m_n   = 0;
          for (int i = 0; i < 8; i++) begin
            if (reg_list[i]) begin
              m_regs[m_n] = 4'(i);
              m_n++;
            end
          end
          if (extra_bit) begin
            m_regs[m_n] = is_pop ? 4'd9 : 4'd10;
            m_n++;
          end
          m_base   = is_pop ? sp_in : sp_in - 32'(4 * m_n);
          m_new_sp = is_pop ? sp_in + 32'(4 * m_n) : sp_in - 32'(4 * m_n);
          m_k      = 0;
          m_phase  = 1;
        end
        1: m_phase = (m_n == 0) ? 4 : 2;
        2: if (mem_ready) begin
          m_k++;
          if (m_k == m_n) m_phase = 3;
        end
        3: m_phase = 4;
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      logic        exp_we;
      logic [31:0] ea;
      ea = m_base + 32'(4 * m_k);
      chk1("busy", busy, m_phase != 0);
      chk1("done", done, m_phase == 4);
      chk1("mem_req", mem_req, m_phase == 2);
      if (m_phase == 2) begin
        chk32("mem_addr", mem_addr, ea);
        chk1("mem_we", mem_we, !m_pop);
        if (!m_pop) begin
          chk32("rf_read_sel", 32'(rf_read_sel), 32'(m_regs[m_k]));
          chk32("mem_wdata", mem_wdata, rf[m_regs[m_k]]);
        end
      end
      exp_we = (m_phase == 2 && m_pop && mem_ready) || m_phase == 3;
      chk1("rf_write_en", rf_write_en, exp_we);
      if (exp_we && m_phase == 3) begin
        chk32("sp_dest", 32'(rf_write_dest), 32'd8);
        chk32("sp_data", rf_write_data, m_new_sp);
      end else if (exp_we) begin
        chk32("pop_dest", 32'(rf_write_dest), 32'(m_regs[m_k]));
        chk32("pop_data", rf_write_data, memw(ea));
      end
    end
  end

  // Issue one request; returns the cycle (edge 0 = start sample) in which done was seen.
  task automatic run_op(input logic pop, input logic [7:0] lst, input logic ext,
                        input logic [31:0] sp, input int stall_from, input int stall_len,
                        input int inj_at, output int done_cyc);
    start = 1'b1; is_pop = pop; reg_list = lst; extra_bit = ext; sp_in = sp;
    mem_ready = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    done_cyc = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (done === 1'b1) done_cyc = c;
      @(posedge clk); #2;
      start = (c == inj_at);
      if (start) begin
        is_pop = ~pop; reg_list = 8'hFF; extra_bit = 1'b1; sp_in = 32'h0000_0800;
      end
      mem_ready = !((c + 1 >= stall_from) && (c + 1 < stall_from + stall_len));
      if (done_cyc >= 0) break;
    end
    start = 1'b0;
    mem_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, w0, r0, d0;
    rst = 1'b1; start = 1'b0; is_pop = 1'b0; reg_list = '0; extra_bit = 1'b0;
    sp_in = '0; mem_ready = 1'b1;
    for (int i = 0; i < 16; i++) rf[i] = 32'h0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk1("rst_rf_we", rf_write_en, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'h0);
    chk32("rst_sel", 32'(rf_read_sel), 32'h0);
    chk32("rst_dest", 32'(rf_write_dest), 32'h0);
    chk32("rst_wdata", rf_write_data, 32'h0);

    // PUSH {R0,R2,LR}
    rf[0] = 32'hA; rf[2] = 32'hB; rf[10] = 32'hC;
    run_op(1'b0, 8'b0000_0101, 1'b1, 32'h0000_1000, 0, 0, -1, dc);
    chk32("push3_done_cycle", 32'(dc), 32'd6);
    chk32("push3_m0", memw(32'h0FF4), 32'hA);
    chk32("push3_m1", memw(32'h0FF8), 32'hB);
    chk32("push3_m2", memw(32'h0FFC), 32'hC);
    chk32("push3_sp", rf[8], 32'h0000_0FF4);

    // POP {R1,PC}
    mem[32'h0FF8 >> 2 & 63] = 32'h11;
    mem[32'h0FFC >> 2 & 63] = 32'h200;
    run_op(1'b1, 8'b0000_0010, 1'b1, 32'h0000_0FF8, 0, 0, -1, dc);
    chk32("pop2_done_cycle", 32'(dc), 32'd5);
    chk32("pop2_r1", rf[1], 32'h11);
    chk32("pop2_pc", rf[9], 32'h200);
    chk32("pop2_sp", rf[8], 32'h0000_1000);

    // POP {R3} with three wait cycles
    mem[0] = 32'h33;
    w0 = wr_cnt;
    run_op(1'b1, 8'b0000_1000, 1'b0, 32'h0000_2000, 2, 3, -1, dc);
    chk32("pop_wait_done_cycle", 32'(dc), 32'd7);
    chk32("pop_wait_r3", rf[3], 32'h33);
    chk32("pop_wait_sp", rf[8], 32'h0000_2004);
    chk32("pop_wait_writes", 32'(wr_cnt - w0), 32'd2);

    // Empty list
    w0 = wr_cnt; r0 = req_cnt;
    run_op(1'b0, 8'h00, 1'b0, 32'h0000_4000, 0, 0, -1, dc);
    chk32("empty_done_cycle", 32'(dc), 32'd2);
    chk32("empty_reqs", 32'(req_cnt - r0), 32'd0);
    chk32("empty_writes", 32'(wr_cnt - w0), 32'd0);

    // PUSH R0-R7+LR wrapping below zero, with a start pulse while busy
    for (int i = 0; i < 8; i++) rf[i] = 32'h100 + 32'(i);
    rf[10] = 32'hAAA;
    r0 = req_cnt;
    run_op(1'b0, 8'hFF, 1'b1, 32'h0000_0010, 0, 0, 4, dc);
    chk32("pushall_done_cycle", 32'(dc), 32'd12);
    chk32("pushall_sp", rf[8], 32'hFFFF_FFEC);
    chk32("pushall_reqs", 32'(req_cnt - r0), 32'd9);
    for (int i = 0; i < 8; i++)
      chk32("pushall_mem", memw(32'hFFFF_FFEC + 32'(4 * i)), 32'h100 + 32'(i));
    chk32("pushall_lr", memw(32'h0000_000C), 32'hAAA);
    chk1("pushall_idle_after", busy, 1'b0);

    // Reset mid-POP {R0,R1,R2} after the second completed access
    mem[0] = 32'h70; mem[1] = 32'h71; mem[2] = 32'h72;
    rf[0] = 32'h0; rf[1] = 32'h0; rf[2] = 32'h0; rf[8] = 32'h5555;
    d0 = done_cnt; w0 = wr_cnt;
    start = 1'b1; is_pop = 1'b1; reg_list = 8'b0000_0111; extra_bit = 1'b0;
    sp_in = 32'h0000_3000; mem_ready = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    repeat (3) begin @(posedge clk); #2; end
    rst = 1'b1; mem_ready = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0; mem_ready = 1'b1;
    chk1("rstmid_busy", busy, 1'b0);
    chk1("rstmid_mem_req", mem_req, 1'b0);
    chk32("rstmid_r0", rf[0], 32'h70);
    chk32("rstmid_r1", rf[1], 32'h71);
    chk32("rstmid_r2", rf[2], 32'h0);
    chk32("rstmid_sp", rf[8], 32'h5555);
    chk32("rstmid_writes", 32'(wr_cnt - w0), 32'd2);
    repeat (3) @(posedge clk);
    #2;
    chk32("rstmid_no_done", 32'(done_cnt - d0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
